function_unit: RTL and testbench
================================

Name: function_unit

Overview:
- Multi-cycle function unit sitting directly downstream of the 8x8-bit register file.
- Consumes DataA/DataB, computes an 8-bit result and drives the register file write port (LD, DR, D_in) for one cycle per operation.
- Single-cycle ALU ops, iterative shifts (1 bit/cycle) and an iterative 8x8 shift-add multiply (low byte), under a start/busy/done handshake driven by the control unit.

Parameters:
- WIDTH, 8, datapath width; must match register file data width.
- MUL_CYCLES, 8, multiply iterations; must equal WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted when busy=0.
- op  input  4  opcode, captured on accept.
- A  input  WIDTH  operand A (register file DataA), captured on accept.
- B  input  WIDTH  operand B (register file DataB), captured on accept.
- dr_in  input  3  destination register, captured on accept.
- busy  output  1  unit occupied; start ignored.
- done  output  1  one-cycle completion pulse.
- LD  output  1  register file load enable (one-cycle pulse).
- DR  output  3  destination register to the register file.
- D_out  output  WIDTH  result to the register file D_in.
- flags  output  4  {V,C,N,Z}; present only with FUNIT_FLAGS_EN.

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, LD = 0; DR = 0; D_out = 0; flags = 0; iteration counter = 0. Reset mid-operation aborts the operation, and no LD pulse follows.
- Opcodes:
  - 0000 MOVA: A
  - 0001 INC: A+1
  - 0010 ADD: A+B
  - 0011 SUB: A-B
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 0111 NOT A
  - 1000 SHR: logical, by B[2:0]
  - 1001 SHL: logical, by B[2:0]
  - 1010 MUL: low WIDTH bits of A*B
  - 1011-1111: reserved
- Arithmetic is modulo 2^WIDTH; carry is taken from bit WIDTH of the WIDTH+1 sum. SUB carry = no-borrow (A>=B).
- States: IDLE, SHIFT, MUL, WB.
  - IDLE & start: capture op/A/B/dr_in.
    - Simple ops and reserved ops compute and go to WB.
    - Shift with B[2:0]=0 goes to WB with result A.
    - Shift otherwise goes to SHIFT with cnt=B[2:0].
    - MUL goes to MUL with acc=0, cnt=MUL_CYCLES.
  - SHIFT: shift 1 bit per cycle, cnt-1; go to WB when cnt reaches 0.
  - MUL: if multiplier LSB=1 then acc+=multiplicand; multiplicand<<=1, multiplier>>=1, cnt-1; go to WB when cnt reaches 0.
  - WB (one cycle): done=1; LD=1, except reserved ops (LD=0, done=1); D_out/DR valid. Next state is IDLE, or a new accept if start=1.
- Latency is counted from the accepting edge to the cycle with done high:
  - 1 cycle for simple ops.
  - 1+n cycles for shifts by n.
  - 1+MUL_CYCLES cycles for MUL.
- Busy rules:
  - busy=1 in SHIFT and MUL.
  - busy=0 in IDLE and WB, so back-to-back issue from WB is allowed.
  - start while busy is ignored and is not queued.
- D_out and DR hold their last values outside WB. LD and done are low outside WB.
- Operand changes after accept have no effect.

Optional Feature:
- Macro: FUNIT_FLAGS_EN.
- With the macro defined:
  - flags port exists and updates only in WB.
  - Z = result==0; N = result MSB.
  - C = carry for ADD/INC/SUB; last bit shifted out for shifts; 0 otherwise.
  - V = signed overflow for ADD/INC/SUB; 0 otherwise.
  - Flags reset to 0.
- Without the macro: no flags port and no flag logic. All other behaviour is identical.

Decomposition:
- Shared package funit_pkg holds:
  - opcode constants;
  - state encoding (IDLE, SHIFT, MUL, WB);
  - WIDTH default;
  - flag bit indices.
- One natural sub-module: funit_alu, a pure combinational single-cycle op block returning result and carry/overflow. The FSM, shifter and multiplier iteration stay in function_unit.

Test Plan:
- ADD A=8'h7F B=8'h01 dr_in=3: done and LD high 1 cycle after accept, D_out=8'h80, DR=3; with flags enabled, V=1 N=1 C=0 Z=0.
- SUB A=8'h05 B=8'h05 dr_in=6, back-to-back with XOR A=8'hF0 B=8'hFF issued in the WB cycle: D_out=8'h00 (Z=1, C=1), then D_out=8'h0F in the next cycle.
- SHL A=8'h81 B=8'h03: busy=1 for 3 cycles, done on cycle 4, D_out=8'h08. SHR by 0 with A=8'h55: D_out=8'h55 after 1 cycle.
- MUL A=8'd13 B=8'd11 dr_in=7: done on cycle 9, D_out=8'h8F (143). A start pulsed while busy is ignored: exactly one LD pulse occurs.
- Reserved op 4'b1100: done=1, LD=0 after 1 cycle.
- RESET asserted asynchronously mid-MUL (cycle 4): busy/LD/done drop immediately, D_out=0, and no LD pulse occurs after RESET deasserts.

Source files
------------

// File: rtl/funit_pkg.sv
// Shared definitions for the function unit: opcodes, FSM states, datapath default and flag bit positions.
package funit_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [3:0] OP_MOVA = 4'b0000;
  localparam logic [3:0] OP_INC  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    WB    = 2'd3
  } state_e;

  // Positions inside the {V,C,N,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  function automatic logic isReserved(input logic [3:0] opCode);
    return (opCode > OP_MUL);
  endfunction

  function automatic logic isShift(input logic [3:0] opCode);
    return (opCode == OP_SHR) || (opCode == OP_SHL);
  endfunction

endpackage

// File: rtl/funit_alu.sv
// Combinational single-cycle operation block for the function unit.
// Iterative ops (shift, multiply) pass A through; the parent sequences them.
module funit_alu
  import funit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] addB;
  logic             addCin;
  logic [WIDTH:0]   sum;
  logic             sumOvf;

  // INC and SUB reuse the adder: INC adds 0 with carry-in, SUB adds ~B with carry-in,
  // so the carry out of SUB is naturally the no-borrow indication.
  always_comb begin
    addB   = b_i;
    addCin = 1'b0;
    if (op_i == OP_INC) begin
      addB   = '0;
      addCin = 1'b1;
    end else if (op_i == OP_SUB) begin
      addB   = ~b_i;
      addCin = 1'b1;
    end
    sum    = {1'b0, a_i} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};
    sumOvf = (a_i[WIDTH-1] == addB[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
  end

  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_i)
      OP_MOVA: result_o = a_i;
      OP_INC, OP_ADD, OP_SUB: begin
        result_o   = sum[WIDTH-1:0];
        carry_o    = sum[WIDTH];
        overflow_o = sumOvf;
      end
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOT:  result_o = ~a_i;
      OP_SHR, OP_SHL, OP_MUL: result_o = a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/function_unit.sv
// Multi-cycle function unit feeding the register file write port (LD/DR/D_out).
// Optional {V,C,N,Z} flags output is built only when FUNIT_FLAGS_EN is defined.
module function_unit
  import funit_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       dr_in,
  output logic             busy,
  output logic             done,
  output logic             LD,
  output logic [2:0]       DR,
  output logic [WIDTH-1:0] D_out
`ifdef FUNIT_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int CW = $clog2(MUL_CYCLES + 1);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       drCap_q, drCap_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [2:0]       drOut_q, drOut_d;

  logic [WIDTH-1:0] aluRes;
  logic             aluC;
  logic             aluV;
  logic [WIDTH-1:0] shifted;
  logic             shiftOut;
  logic [WIDTH-1:0] accNext;

`ifdef FUNIT_FLAGS_EN
  logic [3:0] flags_q, flags_d;

  function automatic logic [3:0] mkFlags(input logic [WIDTH-1:0] res, input logic c,
                                         input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction
`endif

  funit_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i       (op),
    .a_i        (A),
    .b_i        (B),
    .result_o   (aluRes),
    .carry_o    (aluC),
    .overflow_o (aluV)
  );

  // One step of the shifter and of the shift-add multiplier, from the working registers
  always_comb begin
    if (op_q == OP_SHL) begin
      shifted  = {mcand_q[WIDTH-2:0], 1'b0};
      shiftOut = mcand_q[WIDTH-1];
    end else begin
      shifted  = {1'b0, mcand_q[WIDTH-1:1]};
      shiftOut = mcand_q[0];
    end
    accNext = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state logic: IDLE and WB both accept, which gives back-to-back issue from WB.
  // Results and DR are only loaded on the transition into WB so they hold elsewhere.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    drCap_d  = drCap_q;
    dout_d   = dout_q;
    drOut_d  = drOut_q;
`ifdef FUNIT_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      SHIFT: begin
        mcand_d = shifted;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = WB;
          dout_d  = shifted;
          drOut_d = drCap_q;
`ifdef FUNIT_FLAGS_EN
          flags_d = mkFlags(shifted, shiftOut, 1'b0);
`endif
        end
      end
      MUL: begin
        acc_d    = accNext;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = WB;
          dout_d  = accNext;
          drOut_d = drCap_q;
`ifdef FUNIT_FLAGS_EN
          flags_d = mkFlags(accNext, 1'b0, 1'b0);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          op_d     = op;
          mcand_d  = A;
          mplier_d = B;
          drCap_d  = dr_in;
          if (isShift(op) && (B[2:0] != 3'd0)) begin
            state_d = SHIFT;
            cnt_d   = {{(CW-3){1'b0}}, B[2:0]};
          end else if (op == OP_MUL) begin
            state_d = MUL;
            acc_d   = '0;
            cnt_d   = CW'(MUL_CYCLES);
          end else begin
            state_d = WB;
            dout_d  = aluRes;
            drOut_d = dr_in;
`ifdef FUNIT_FLAGS_EN
            flags_d = mkFlags(aluRes, aluC, aluV);
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      drCap_q  <= '0;
      dout_q   <= '0;
      drOut_q  <= '0;
`ifdef FUNIT_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      drCap_q  <= drCap_d;
      dout_q   <= dout_d;
      drOut_q  <= drOut_d;
`ifdef FUNIT_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  // Reserved opcodes still complete (done) but never write the register file
  assign busy  = (state_q == SHIFT) || (state_q == MUL);
  assign done  = (state_q == WB);
  assign LD    = (state_q == WB) && !isReserved(op_q);
  assign DR    = drOut_q;
  assign D_out = dout_q;
`ifdef FUNIT_FLAGS_EN
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_function_unit.sv
// Scoreboard bench for function_unit: stimulus pushes hand-computed expectations, a monitor
// pops and compares on every done pulse. Flag checks are compiled in with FUNIT_FLAGS_EN.
module tb_function_unit;

  logic       CLK;
  logic       RESET;
  logic       start;
  logic [3:0] op;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] dr_in;
  logic       busy;
  logic       done;
  logic       LD;
  logic [2:0] DR;
  logic [7:0] D_out;
`ifdef FUNIT_FLAGS_EN
  logic [3:0] flags;
`endif

  typedef struct {
    logic [7:0] dout;
    logic [2:0] dr;
    logic       ld;
    logic       chkData;
    logic [3:0] flg;
    int         doneCycle;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   cycleCnt = 0;
  int   ldCount  = 0;
  int   ldBase;
  int   checks   = 0;
  int   passes   = 0;

  function_unit dut (
    .CLK   (CLK),
    .RESET (RESET),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .dr_in (dr_in),
    .busy  (busy),
    .done  (done),
    .LD    (LD),
    .DR    (DR),
    .D_out (D_out)
`ifdef FUNIT_FLAGS_EN
    ,
    .flags (flags)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge CLK) begin
    if (!RESET && LD) ldCount++;
    if (!RESET && done) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("doneCycle", cycleCnt, monE.doneCycle);
        checkOutput("LD", {31'd0, LD}, {31'd0, monE.ld});
        if (monE.chkData) begin
          checkOutput("D_out", {24'd0, D_out}, {24'd0, monE.dout});
          checkOutput("DR", {29'd0, DR}, {29'd0, monE.dr});
`ifdef FUNIT_FLAGS_EN
          checkOutput("flags", {28'd0, flags}, {28'd0, monE.flg});
`endif
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic applyStimulus(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] d, input logic [7:0] expD, input logic expLd,
                               input logic chk, input logic [3:0] expF, input int lat);
    exp_t e;
    e.dout = expD; e.dr = d; e.ld = expLd; e.chkData = chk; e.flg = expF;
    e.doneCycle = cycleCnt + lat;
    sbQ.push_back(e);
    start = 1'b1; op = o; A = a; B = b; dr_in = d;
    @(posedge CLK);
    #1;
    start = 1'b0;
    op    = 4'($urandom);
    A     = 8'($urandom);
    B     = 8'($urandom);
    dr_in = 3'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic waitDrain();
    int k = 0;
    while (sbQ.size() != 0 && k < 60) begin
      @(posedge CLK);
      #1;
      k++;
    end
    if (sbQ.size() != 0) checkOutput("drainTimeout", sbQ.size(), 32'd0);
    idle(1);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; dr_in = '0;
    #7;
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstLD", {31'd0, LD}, 32'd0);
    checkOutput("rstDR", {29'd0, DR}, 32'd0);
    checkOutput("rstDout", {24'd0, D_out}, 32'd0);
`ifdef FUNIT_FLAGS_EN
    checkOutput("rstFlags", {28'd0, flags}, 32'd0);
`endif
    @(negedge CLK);
    RESET = 1'b0;
    idle(1);

    // ADD with signed overflow: flags {V,C,N,Z} = 1010
    applyStimulus(4'b0010, 8'h7F, 8'h01, 3'd3, 8'h80, 1'b1, 1'b1, 4'b1010, 1);
    waitDrain();

    // SUB to zero, XOR issued in the SUB writeback cycle
    applyStimulus(4'b0011, 8'h05, 8'h05, 3'd6, 8'h00, 1'b1, 1'b1, 4'b0101, 1);
    applyStimulus(4'b0110, 8'hF0, 8'hFF, 3'd2, 8'h0F, 1'b1, 1'b1, 4'b0000, 1);
    waitDrain();

    // SHL by 3: busy for three cycles, done in the fourth
    applyStimulus(4'b1001, 8'h81, 8'h03, 3'd1, 8'h08, 1'b1, 1'b1, 4'b0000, 4);
    checkOutput("shlBusy1", {31'd0, busy}, 32'd1);
    idle(1);
    checkOutput("shlBusy2", {31'd0, busy}, 32'd1);
    idle(1);
    checkOutput("shlBusy3", {31'd0, busy}, 32'd1);
    idle(1);
    checkOutput("shlBusyWb", {31'd0, busy}, 32'd0);
    checkOutput("shlDoneWb", {31'd0, done}, 32'd1);
    waitDrain();

    // SHR by 0 completes like a simple op
    applyStimulus(4'b1000, 8'h55, 8'hF8, 3'd5, 8'h55, 1'b1, 1'b1, 4'b0000, 1);
    waitDrain();

    // MUL 13*11 with an ignored start pulse while busy
    ldBase = ldCount;
    applyStimulus(4'b1010, 8'd13, 8'd11, 3'd7, 8'h8F, 1'b1, 1'b1, 4'b0010, 9);
    idle(2);
    start = 1'b1; op = 4'b0010; A = 8'h11; B = 8'h22; dr_in = 3'd4;
    idle(1);
    start = 1'b0;
    idle(8);
    checkOutput("mulLdPulses", ldCount - ldBase, 32'd1);
    waitDrain();

    // Reserved opcode: done without LD
    applyStimulus(4'b1100, 8'h12, 8'h34, 3'd2, 8'h00, 1'b0, 1'b0, 4'b0000, 1);
    waitDrain();

    // Further patterns: wrap, borrow, right shift carry-out, multiply wrap, logic ops
    applyStimulus(4'b0001, 8'hFF, 8'h00, 3'd1, 8'h00, 1'b1, 1'b1, 4'b0101, 1);
    waitDrain();
    applyStimulus(4'b0011, 8'h03, 8'h05, 3'd2, 8'hFE, 1'b1, 1'b1, 4'b0010, 1);
    waitDrain();
    applyStimulus(4'b1000, 8'h83, 8'h02, 3'd3, 8'h20, 1'b1, 1'b1, 4'b0100, 3);
    waitDrain();
    applyStimulus(4'b1010, 8'hFF, 8'hFF, 3'd4, 8'h01, 1'b1, 1'b1, 4'b0000, 9);
    waitDrain();
    applyStimulus(4'b0111, 8'h0F, 8'h00, 3'd5, 8'hF0, 1'b1, 1'b1, 4'b0010, 1);
    waitDrain();
    applyStimulus(4'b0000, 8'h00, 8'h77, 3'd6, 8'h00, 1'b1, 1'b1, 4'b0001, 1);
    waitDrain();
    applyStimulus(4'b0100, 8'hF0, 8'h3C, 3'd7, 8'h30, 1'b1, 1'b1, 4'b0000, 1);
    waitDrain();
    applyStimulus(4'b0101, 8'hF0, 8'h0F, 3'd5, 8'hFF, 1'b1, 1'b1, 4'b0010, 1);
    waitDrain();

    // Asynchronous reset in the fourth MUL cycle aborts without writeback
    applyStimulus(4'b1010, 8'd13, 8'd11, 3'd7, 8'h8F, 1'b1, 1'b1, 4'b0010, 9);
    idle(3);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortLD", {31'd0, LD}, 32'd0);
    checkOutput("abortDone", {31'd0, done}, 32'd0);
    checkOutput("abortDout", {24'd0, D_out}, 32'd0);
    checkOutput("abortDR", {29'd0, DR}, 32'd0);
    sbQ.delete();
    ldBase = ldCount;
    @(negedge CLK);
    RESET = 1'b0;
    idle(15);
    checkOutput("abortNoLd", ldCount - ldBase, 32'd0);
    checkOutput("abortIdle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
